// File: rtl/latch_change_fifo.sv
// Watches the settled latch output, turns each value change into a {timestamp, value}
// event and queues it in a small FIFO drained over a valid/ready port.
module latch_change_fifo #(
   parameter int WIDTH    = 4,
   parameter int DEPTH    = 8,
   parameter int TS_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [WIDTH-1:0]          d_in,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH+TS_WIDTH-1:0] out_data,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      full,
   output logic                      overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = WIDTH + TS_WIDTH;
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0]    prev_q, prev_d;
   logic                primed_q, primed_d;
   logic [TS_WIDTH-1:0] ts_q, ts_d;
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [AW:0]         count_q, count_d;
   logic                valid_q, valid_d;
   logic                full_q, full_d;
   logic                overflow_q, overflow_d;

   logic                push_req, push_ok, pop;
   logic [EW-1:0]       mem [DEPTH];

   always_comb begin
      push_req   = primed_q && (d_in != prev_q);
      pop        = valid_q && out_ready;
      // A pop frees a slot on the same edge, so a full FIFO still accepts the push.
      push_ok    = push_req && (!full_q || pop);

      prev_d     = d_in;
      primed_d   = 1'b1;
      ts_d       = ts_q + 1'b1;
      wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

      count_d    = count_q;
      if (push_ok && !pop)
         count_d = count_q + 1'b1;
      else if (pop && !push_ok)
         count_d = count_q - 1'b1;

      valid_d    = (count_d != '0);
      full_d     = (count_d == DEPTH_C);
      overflow_d = overflow_q || (push_req && !push_ok);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q     <= '0;
         primed_q   <= 1'b0;
         ts_q       <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         valid_q    <= 1'b0;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         prev_q     <= prev_d;
         primed_q   <= primed_d;
         ts_q       <= ts_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         valid_q    <= valid_d;
         full_q     <= full_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage carries no reset; validity is tracked entirely by the pointers and count.
   always_ff @(posedge clk) begin
      if (!rst && push_ok)
         mem[wr_ptr_q] <= {ts_q, d_in};
   end

   assign out_data  = mem[rd_ptr_q];
   assign out_valid = valid_q;
   assign count     = count_q;
   assign full      = full_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_latch_change_fifo.sv
// Directed bench for latch_change_fifo: stimulus queues expected events,
// a negedge monitor checks every popped entry against that queue.
module tb_latch_change_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  d_in;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] out_data;
   logic [3:0]  count;
   logic        full;
   logic        overflow;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [11:0] exp_q[$];

   latch_change_fifo #(.WIDTH(4), .DEPTH(8), .TS_WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .d_in      (d_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count),
      .full      (full),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [7:0] ts, input logic [3:0] v);
      exp_q.push_back({ts, v});
   endtask

   // Monitor: an entry presented with out_ready high is consumed at the next edge.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("pop_unexpected", int'(out_data), -1);
         end else begin
            logic [11:0] e;
            e = exp_q.pop_front();
            chk("pop_data", int'(out_data), int'(e));
            $display("pop: data=%03h expected=%03h", out_data, e);
         end
      end
   end

   initial begin
      // Reset and priming
      rst = 1'b1; d_in = 4'h1; out_ready = 1'b0;
      step(2);
      chk("reset_valid", int'(out_valid), 0);
      chk("reset_count", int'(count), 0);
      chk("reset_overflow", int'(overflow), 0);
      chk("reset_full", int'(full), 0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         chk("prime_valid", int'(out_valid), 0);
         chk("prime_count", int'(count), 0);
         chk("prime_overflow", int'(overflow), 0);
      end

      // Single change at ts=3
      rst = 1'b1; step(1); rst = 1'b0;
      d_in = 4'h1; step(3);
      d_in = 4'h0; push_exp(8'd3, 4'h0); step(1);
      chk("single_valid", int'(out_valid), 1);
      chk("single_data", int'(out_data), 12'h030);
      chk("single_count", int'(count), 1);
      out_ready = 1'b1; step(1); out_ready = 1'b0;
      chk("single_pop_valid", int'(out_valid), 0);
      chk("single_pop_count", int'(count), 0);

      // Fill and overflow: ten toggles starting at ts=5, last two dropped
      for (int k = 0; k < 10; k++) begin
         d_in = (k % 2 == 0) ? 4'h1 : 4'h0;
         if (k < 8) push_exp(8'(5 + k), d_in);
         step(1);
         if (k == 7) begin
            chk("fill_count", int'(count), 8);
            chk("fill_full", int'(full), 1);
            chk("fill_overflow", int'(overflow), 0);
         end
         if (k == 8) begin
            chk("ovf_set", int'(overflow), 1);
            chk("ovf_count", int'(count), 8);
         end
      end
      out_ready = 1'b1; step(8); out_ready = 1'b0;
      chk("drain_count", int'(count), 0);
      chk("drain_full", int'(full), 0);
      chk("drain_valid", int'(out_valid), 0);
      chk("drain_overflow_sticky", int'(overflow), 1);

      // Push and pop on the same edge while full
      rst = 1'b1; step(1); rst = 1'b0;
      d_in = 4'h0; step(1);
      for (int k = 0; k < 8; k++) begin
         d_in = (k % 2 == 0) ? 4'h1 : 4'h0;
         push_exp(8'(1 + k), d_in);
         step(1);
      end
      chk("pp_full_before", int'(full), 1);
      d_in = 4'h1; out_ready = 1'b1; push_exp(8'd9, 4'h1);
      step(1);
      chk("pp_count", int'(count), 8);
      chk("pp_full", int'(full), 1);
      chk("pp_overflow", int'(overflow), 0);
      step(8); out_ready = 1'b0;
      chk("pp_drain_count", int'(count), 0);

      // Wrap-around: change every 7 edges, timestamps cross 252 -> 3
      rst = 1'b1; step(1); rst = 1'b0;
      d_in = 4'h0; out_ready = 1'b1; step(1);
      for (int i = 1; i <= 300; i++) begin
         if (i % 7 == 0) begin
            d_in = d_in + 4'h1;
            push_exp(8'(i), d_in);
         end
         step(1);
      end
      step(2); out_ready = 1'b0;
      chk("wrap_count", int'(count), 0);
      chk("wrap_overflow", int'(overflow), 0);

      // Reset mid-operation with 5 stored and overflow set
      rst = 1'b1; step(1); rst = 1'b0;
      d_in = 4'h0; step(1);
      for (int k = 0; k < 9; k++) begin
         d_in = (k % 2 == 0) ? 4'h1 : 4'h0;
         if (k < 8) push_exp(8'(1 + k), d_in);
         step(1);
      end
      chk("mid_overflow", int'(overflow), 1);
      out_ready = 1'b1; step(3); out_ready = 1'b0;
      chk("mid_count", int'(count), 5);
      chk("mid_overflow_kept", int'(overflow), 1);
      rst = 1'b1; d_in = 4'h9; exp_q.delete();
      step(1);
      chk("rst_mid_count", int'(count), 0);
      chk("rst_mid_valid", int'(out_valid), 0);
      chk("rst_mid_overflow", int'(overflow), 0);
      chk("rst_mid_full", int'(full), 0);
      rst = 1'b0; d_in = 4'hA;
      step(1);
      chk("reprime_count", int'(count), 0);
      chk("reprime_valid", int'(out_valid), 0);
      step(1);
      chk("reprime_hold_count", int'(count), 0);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
